// File: rtl/car_draw_pkg.sv
// Shared types and constants for the car frame scheduler.
// States, headings, go codes and the per-heading unit vector.
package car_draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE   = 15;

  localparam logic signed [8:0] X_MAX = 9'(SCREEN_W - SPRITE);
  localparam logic signed [8:0] Y_MAX = 9'(SCREEN_H - SPRITE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ERASE,
    S_ERASE_WAIT,
    S_MOVE,
    S_DRAW,
    S_DRAW_WAIT
  } state_t;

  typedef enum logic [2:0] {
    DIR_N, DIR_NE, DIR_E, DIR_SE,
    DIR_S, DIR_SW, DIR_W, DIR_NW
  } dir_t;

  localparam logic [1:0] GO_FWD  = 2'b11;
  localparam logic [1:0] GO_BACK = 2'b10;

  function automatic logic signed [8:0] dir_dx(input logic [2:0] d);
    case (d)
      DIR_NE, DIR_E, DIR_SE: dir_dx = 9'sd1;
      DIR_SW, DIR_W, DIR_NW: dir_dx = -9'sd1;
      default:               dir_dx = 9'sd0;
    endcase
  endfunction

  // y grows downward, so north is -1
  function automatic logic signed [8:0] dir_dy(input logic [2:0] d);
    case (d)
      DIR_N, DIR_NE, DIR_NW: dir_dy = -9'sd1;
      DIR_SE, DIR_S, DIR_SW: dir_dy = 9'sd1;
      default:               dir_dy = 9'sd0;
    endcase
  endfunction

endpackage

// File: rtl/car_frame_scheduler_scanner.sv
// Full-screen raster scanner used for screen clears.
// Emits one pixel per cycle while run is high, x inner loop.
module screen_clear_scanner
  import car_draw_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       valid,
  output logic       done
);

  logic x_last;
  logic y_last;

  assign x_last = (x == 8'(SCREEN_W - 1));
  assign y_last = (y == 7'(SCREEN_H - 1));

  // counters sit at the origin whenever not running
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      x <= '0;
      y <= '0;
    end else if (x_last) begin
      x <= '0;
      y <= y_last ? '0 : y + 7'd1;
    end else begin
      x <= x + 8'd1;
    end
  end

  assign valid = run;
  assign done  = run && x_last && y_last;

endmodule

// File: rtl/car_frame_scheduler.sv
// Per-frame erase/move/draw sequencer for the car sprite.
// Owns the VGA plot port and runs full-screen clears.
module car_frame_scheduler
  import car_draw_pkg::*;
#(
  parameter int START_X = 72,
  parameter int START_Y = 52,
  parameter int STEP    = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iFrameTick,
  input  logic       iClearReq,
  input  logic [2:0] iDir,
  input  logic [1:0] iGo,
  output logic       oDrawStart,
  output logic       oErase,
  output logic [7:0] oDrawX,
  output logic [6:0] oDrawY,
  output logic [2:0] oDrawDir,
  input  logic       iDrawDone,
  input  logic [7:0] iDrawX,
  input  logic [6:0] iDrawY,
  input  logic [8:0] iDrawColour,
  input  logic       iDrawPlot,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [8:0] oColour,
  output logic       oPlot,
  output logic       oBusy,
  output logic       oFault,
  output logic [7:0] oMissed
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [8:0] STEP9 = 9'(STEP);

  state_t state, next;

  logic [7:0]    pos_x;
  logic [6:0]    pos_y;
  logic [2:0]    last_dir;
  logic [2:0]    snap_dir;
  logic [1:0]    snap_go;
  logic          tick_pend;
  logic          clr_pend;
  logic [CW-1:0] wait_cnt;

  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic       scan_valid;
  logic       scan_done;

  logic in_erase;
  logic in_draw;
  logic in_wait;
  logic timed_out;
  logic go_moving;
  logic want_clr;
  logic want_tick;

  logic signed [8:0] dx, dy, nx, ny;
  logic [7:0]        new_x;
  logic [6:0]        new_y;

  screen_clear_scanner u_scan (
    .clk   (iClock),
    .reset (iReset),
    .run   (state == S_CLEAR),
    .x     (scan_x),
    .y     (scan_y),
    .valid (scan_valid),
    .done  (scan_done)
  );

  assign in_erase  = (state == S_ERASE) || (state == S_ERASE_WAIT);
  assign in_draw   = (state == S_DRAW) || (state == S_DRAW_WAIT);
  assign in_wait   = (state == S_ERASE_WAIT) || (state == S_DRAW_WAIT);
  assign timed_out = in_wait && !iDrawDone
                  && (wait_cnt == CW'(TIMEOUT - 1));
  assign go_moving = (iGo == GO_FWD) || (iGo == GO_BACK);
  assign want_clr  = clr_pend || iClearReq;
  assign want_tick = tick_pend || iFrameTick;

  always_ff @(posedge iClock) begin
    if (iReset) state <= S_CLEAR;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_CLEAR:
        if (scan_done) next = S_DRAW;
      S_IDLE:
        if (want_clr)
          next = S_CLEAR;
        else if (want_tick && (go_moving || iDir != last_dir))
          next = S_ERASE;
      S_ERASE:
        next = S_ERASE_WAIT;
      S_ERASE_WAIT:
        if (iDrawDone)      next = S_MOVE;
        else if (timed_out) next = S_IDLE;
      S_MOVE:
        next = S_DRAW;
      S_DRAW:
        next = S_DRAW_WAIT;
      S_DRAW_WAIT:
        if (iDrawDone || timed_out) next = S_IDLE;
      default:
        next = S_IDLE;
    endcase
  end

  always_comb begin
    oDrawStart = (state == S_ERASE) || (state == S_DRAW);
    oErase     = in_erase;
    oDrawX     = (in_erase || in_draw) ? pos_x : '0;
    oDrawY     = (in_erase || in_draw) ? pos_y : '0;
    oDrawDir   = (in_erase || in_draw) ? last_dir : '0;
    oBusy      = (state != S_IDLE);
  end

  // signed 9-bit step, then clamp so the box stays on screen
  always_comb begin
    dx = dir_dx(snap_dir) * STEP9;
    dy = dir_dy(snap_dir) * STEP9;
    nx = signed'({1'b0, pos_x});
    ny = signed'({2'b0, pos_y});
    unique case (snap_go)
      GO_FWD:  begin nx = nx + dx; ny = ny + dy; end
      GO_BACK: begin nx = nx - dx; ny = ny - dy; end
      default: ;
    endcase
    if (nx < 9'sd0)      new_x = '0;
    else if (nx > X_MAX) new_x = X_MAX[7:0];
    else                 new_x = nx[7:0];
    if (ny < 9'sd0)      new_y = '0;
    else if (ny > Y_MAX) new_y = Y_MAX[6:0];
    else                 new_y = ny[6:0];
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      pos_x     <= 8'(START_X);
      pos_y     <= 7'(START_Y);
      last_dir  <= '0;
      snap_dir  <= '0;
      snap_go   <= '0;
      tick_pend <= 1'b0;
      clr_pend  <= 1'b0;
      wait_cnt  <= '0;
      oFault    <= 1'b0;
      oMissed   <= '0;
      oX        <= '0;
      oY        <= '0;
      oColour   <= '0;
      oPlot     <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (want_clr) begin
          clr_pend <= 1'b0;
          if (iFrameTick) begin
            tick_pend <= 1'b1;
            if (tick_pend && oMissed != 8'hFF)
              oMissed <= oMissed + 8'd1;
          end
        end else if (want_tick) begin
          tick_pend <= tick_pend && iFrameTick;
          snap_dir  <= iDir;
          snap_go   <= iGo;
        end
      end else begin
        if (iFrameTick) begin
          if (!tick_pend)
            tick_pend <= 1'b1;
          else if (oMissed != 8'hFF)
            oMissed <= oMissed + 8'd1;
        end
        if (iClearReq && state != S_CLEAR)
          clr_pend <= 1'b1;
      end

      wait_cnt <= in_wait ? wait_cnt + 1'b1 : '0;
      if (timed_out)
        oFault <= 1'b1;

      if (state == S_MOVE) begin
        pos_x    <= new_x;
        pos_y    <= new_y;
        last_dir <= snap_dir;
      end

      if (state == S_CLEAR) begin
        oX      <= scan_x;
        oY      <= scan_y;
        oColour <= '0;
        oPlot   <= scan_valid;
      end else begin
        oX      <= iDrawX;
        oY      <= iDrawY;
        oColour <= iDrawColour;
        oPlot   <= iDrawPlot;
      end
    end
  end

endmodule

// File: tb/tb_car_frame_scheduler.sv
// Directed bench for car_frame_scheduler with a scripted drawer.
// Expected positions and counts are worked out by hand below.
module tb_car_frame_scheduler;

  logic       clk;
  logic       iReset;
  logic       iFrameTick;
  logic       iClearReq;
  logic [2:0] iDir;
  logic [1:0] iGo;
  logic       oDrawStart;
  logic       oErase;
  logic [7:0] oDrawX;
  logic [6:0] oDrawY;
  logic [2:0] oDrawDir;
  logic       iDrawDone;
  logic [7:0] iDrawX;
  logic [6:0] iDrawY;
  logic [8:0] iDrawColour;
  logic       iDrawPlot;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [8:0] oColour;
  logic       oPlot;
  logic       oBusy;
  logic       oFault;
  logic [7:0] oMissed;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       e;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] d;
  } st_t;

  st_t q[$];

  car_frame_scheduler dut (
    .iClock      (clk),
    .iReset      (iReset),
    .iFrameTick  (iFrameTick),
    .iClearReq   (iClearReq),
    .iDir        (iDir),
    .iGo         (iGo),
    .oDrawStart  (oDrawStart),
    .oErase      (oErase),
    .oDrawX      (oDrawX),
    .oDrawY      (oDrawY),
    .oDrawDir    (oDrawDir),
    .iDrawDone   (iDrawDone),
    .iDrawX      (iDrawX),
    .iDrawY      (iDrawY),
    .iDrawColour (iDrawColour),
    .iDrawPlot   (iDrawPlot),
    .oX          (oX),
    .oY          (oY),
    .oColour     (oColour),
    .oPlot       (oPlot),
    .oBusy       (oBusy),
    .oFault      (oFault),
    .oMissed     (oMissed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (oDrawStart)
      q.push_back('{oErase, oDrawX, oDrawY, oDrawDir});

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic pulse_tick();
    iFrameTick = 1'b1;
    @(negedge clk);
    iFrameTick = 1'b0;
  endtask

  task automatic done_pulse();
    @(negedge clk);
    iDrawDone = 1'b1;
    @(negedge clk);
    iDrawDone = 1'b0;
  endtask

  task automatic expect_start(input string tag, input logic e,
                              input int x, input int y,
                              input logic [2:0] d);
    st_t s;
    for (int i = 0; i < 200 && q.size() == 0; i++)
      @(negedge clk);
    if (q.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      s = q.pop_front();
      chk({tag, "_erase"}, 32'(s.e), 32'(e));
      chk({tag, "_x"}, 32'(s.x), x);
      chk({tag, "_y"}, 32'(s.y), y);
      chk({tag, "_dir"}, 32'(s.d), 32'(d));
    end
  endtask

  task automatic frame(input logic [2:0] d, input logic [1:0] g,
                       input int ex, input int ey,
                       input logic [2:0] ed,
                       input int nx, input int ny);
    iDir = d;
    iGo  = g;
    pulse_tick();
    expect_start("erase", 1'b1, ex, ey, ed);
    done_pulse();
    expect_start("draw", 1'b0, nx, ny, d);
    done_pulse();
    repeat (2) @(negedge clk);
  endtask

  // limit > 0 stops after that many pixels (used for mid-clear reset)
  task automatic check_clear(input string tag, input int limit);
    int n, bad;
    logic [7:0] fx, lx;
    logic [6:0] fy, ly;
    n = 0;
    bad = 0;
    lx = '0;
    ly = '0;
    for (int i = 0; i < 50 && !oPlot; i++)
      @(negedge clk);
    fx = oX;
    fy = oY;
    while (oPlot && n < 19300 && (limit == 0 || n < limit)) begin
      if (oColour !== 9'd0) bad++;
      lx = oX;
      ly = oY;
      n++;
      @(negedge clk);
    end
    chk({tag, "_x0"}, 32'(fx), 0);
    chk({tag, "_y0"}, 32'(fy), 0);
    if (limit == 0) begin
      chk({tag, "_count"}, n, 19200);
      chk({tag, "_xlast"}, 32'(lx), 159);
      chk({tag, "_ylast"}, 32'(ly), 119);
      chk({tag, "_colour"}, bad, 0);
    end else begin
      chk({tag, "_partial"}, n, limit);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ld;
    iReset      = 1'b1;
    iFrameTick  = 1'b0;
    iClearReq   = 1'b0;
    iDir        = 3'd0;
    iGo         = 2'b00;
    iDrawDone   = 1'b0;
    iDrawX      = '0;
    iDrawY      = '0;
    iDrawColour = '0;
    iDrawPlot   = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy", 32'(oBusy), 1);
    chk("rst_plot", 32'(oPlot), 0);
    chk("rst_start", 32'(oDrawStart), 0);
    chk("rst_drawx", 32'(oDrawX), 0);
    chk("rst_missed", 32'(oMissed), 0);
    chk("rst_fault", 32'(oFault), 0);
    iReset = 1'b0;

    check_clear("clr0", 0);
    expect_start("init", 1'b0, 72, 52, 3'd0);
    done_pulse();
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(oBusy), 0);

    frame(3'd2, 2'b11, 72, 52, 3'd0, 73, 52);
    for (int i = 0; i < 72; i++)
      frame(3'd2, 2'b11, 73 + i, 52, 3'd2, 74 + i, 52);
    frame(3'd2, 2'b11, 145, 52, 3'd2, 145, 52);
    frame(3'd1, 2'b11, 145, 52, 3'd2, 145, 51);
    frame(3'd0, 2'b10, 145, 51, 3'd1, 145, 52);
    ld = 0;
    for (int i = 0; i < 53; i++) begin
      frame(3'd4, 2'b11, 145, 52 + i, 3'(ld), 145, 53 + i);
      ld = 4;
    end
    frame(3'd4, 2'b11, 145, 105, 3'd4, 145, 105);

    iDir = 3'd6;
    iGo  = 2'b11;
    pulse_tick();
    expect_start("mis_er", 1'b1, 145, 105, 3'd4);
    repeat (3) pulse_tick();
    done_pulse();
    expect_start("mis_dr", 1'b0, 144, 105, 3'd6);
    done_pulse();
    expect_start("pend_er", 1'b1, 144, 105, 3'd6);
    done_pulse();
    expect_start("pend_dr", 1'b0, 143, 105, 3'd6);
    done_pulse();
    repeat (2) @(negedge clk);
    chk("missed", 32'(oMissed), 2);

    iGo = 2'b00;
    pulse_tick();
    repeat (20) @(negedge clk);
    chk("stop_nostart", q.size(), 0);
    chk("stop_busy", 32'(oBusy), 0);

    iGo = 2'b11;
    pulse_tick();
    expect_start("to_er", 1'b1, 143, 105, 3'd6);
    repeat (1000) @(negedge clk);
    chk("to_early", 32'(oFault), 0);
    repeat (100) @(negedge clk);
    chk("to_fault", 32'(oFault), 1);
    chk("to_busy", 32'(oBusy), 0);
    frame(3'd6, 2'b11, 143, 105, 3'd6, 142, 105);

    iDrawX      = 8'd33;
    iDrawY      = 7'd44;
    iDrawColour = 9'h1A5;
    iDrawPlot   = 1'b1;
    @(negedge clk);
    chk("pass_plot", 32'(oPlot), 1);
    chk("pass_x", 32'(oX), 33);
    chk("pass_y", 32'(oY), 44);
    chk("pass_col", 32'(oColour), 32'h1A5);
    iDrawPlot   = 1'b0;
    iDrawColour = 9'h1FF;
    @(negedge clk);

    pulse_tick();
    expect_start("cw_er", 1'b1, 142, 105, 3'd6);
    done_pulse();
    expect_start("cw_dr", 1'b0, 141, 105, 3'd6);
    iClearReq = 1'b1;
    @(negedge clk);
    iClearReq = 1'b0;
    done_pulse();
    check_clear("clr1", 0);
    expect_start("cw_redraw", 1'b0, 141, 105, 3'd6);
    done_pulse();
    repeat (2) @(negedge clk);

    iClearReq = 1'b1;
    @(negedge clk);
    iClearReq = 1'b0;
    check_clear("clr2", 5000);
    iReset = 1'b1;
    repeat (2) @(negedge clk);
    iReset = 1'b0;
    q.delete();
    chk("rr_missed", 32'(oMissed), 0);
    chk("rr_fault", 32'(oFault), 0);
    check_clear("clr3", 0);
    expect_start("rr_draw", 1'b0, 72, 52, 3'd0);
    done_pulse();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
